// File: rtl/router_reg_block.sv
// Datapath register stage of the 1-to-3 packet router: latches the header, drives the FIFO write
// bus, holds one byte while the FIFO is full, and checks XOR parity against the trailing byte.
module router_reg_block (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic       fifo_full,
  input  logic       detect_add,
  input  logic       ld_state,
  input  logic       laf_state,
  input  logic       full_state,
  input  logic       lfd_state,
  input  logic       rst_int_reg,
  input  logic [7:0] data_in,
  output logic       err,
  output logic       parity_done,
  output logic       low_pkt_valid,
  output logic [7:0] dout
);

  logic [7:0] r_header;
  logic [7:0] r_full_byte;
  logic [7:0] r_int_parity;
  logic [7:0] r_pkt_parity;

  logic w_addr_ok;
  logic w_lfd;
  logic w_ld;
  logic w_laf;

  // Strobes should be one-hot; if they are not, detect_add > lfd > ld > laf.
  assign w_addr_ok = (data_in[1:0] != 2'b11);
  assign w_lfd     = lfd_state & ~detect_add;
  assign w_ld      = ld_state  & ~detect_add & ~lfd_state;
  assign w_laf     = laf_state & ~detect_add & ~lfd_state & ~ld_state;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      r_header      <= 8'h00;
      r_full_byte   <= 8'h00;
      r_int_parity  <= 8'h00;
      r_pkt_parity  <= 8'h00;
      dout          <= 8'h00;
      err           <= 1'b0;
      parity_done   <= 1'b0;
      low_pkt_valid <= 1'b0;
    end else begin
      if (detect_add && pkt_valid && w_addr_ok)
        r_header <= data_in;

      if (w_lfd)
        dout <= r_header;
      else if (w_ld && !fifo_full)
        dout <= data_in;
      else if (w_laf)
        dout <= r_full_byte;

      if (w_ld && fifo_full)
        r_full_byte <= data_in;

      if (detect_add)
        r_int_parity <= 8'h00;
      else if (w_lfd)
        r_int_parity <= r_int_parity ^ r_header;
      else if (w_ld && pkt_valid && !full_state)
        r_int_parity <= r_int_parity ^ data_in;

      // The parity byte arrives with pkt_valid low and is kept apart from the running XOR.
      if (detect_add)
        r_pkt_parity <= 8'h00;
      else if (w_ld && !pkt_valid)
        r_pkt_parity <= data_in;

      if (rst_int_reg)
        low_pkt_valid <= 1'b0;
      else if (w_ld && !pkt_valid)
        low_pkt_valid <= 1'b1;

      if (detect_add)
        parity_done <= 1'b0;
      else if ((w_ld && !fifo_full && !pkt_valid) || (w_laf && low_pkt_valid && !parity_done))
        parity_done <= 1'b1;

      if (detect_add)
        err <= 1'b0;
      else if (parity_done)
        err <= (r_int_parity != r_pkt_parity);
    end
  end

endmodule

// File: tb/tb_router_reg_block.sv
// Self-checking bench for router_reg_block: a spec-level model feeds a scoreboard queue each cycle,
// plus directed checks on the key scenario results.
module tb_router_reg_block;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, ld_state, laf_state;
  logic       full_state, lfd_state, rst_int_reg;
  logic [7:0] data_in;
  logic       err, parity_done, low_pkt_valid;
  logic [7:0] dout;

  int n_checks = 0;
  int n_errors = 0;
  int step     = 0;

  router_reg_block dut (
    .clock        (clock),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .lfd_state    (lfd_state),
    .rst_int_reg  (rst_int_reg),
    .data_in      (data_in),
    .err          (err),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .dout         (dout)
  );

  always #5 clock = ~clock;

  typedef enum {A_NONE, A_DET, A_LFD, A_LD, A_LAF} act_e;

  typedef struct {
    logic [7:0] dout;
    logic       err;
    logic       pd;
    logic       lpv;
    logic [7:0] hdr;
    logic [7:0] fbr;
    logic [7:0] ip;
    logic [7:0] pp;
  } model_t;

  typedef struct {
    logic [7:0] dout;
    logic       err;
    logic       pd;
    logic       lpv;
  } exp_t;

  model_t m;
  exp_t   sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic model_t model_reset();
    model_t z;
    z.dout = 8'h00; z.err = 1'b0; z.pd = 1'b0; z.lpv = 1'b0;
    z.hdr  = 8'h00; z.fbr = 8'h00; z.ip = 8'h00; z.pp = 8'h00;
    return z;
  endfunction

  function automatic model_t model_step(input model_t c, input logic da, lfd, ld, laf, fs, pv, ff, ri,
                                       input logic [7:0] d);
    model_t n = c;
    act_e   act;
    act = da ? A_DET : lfd ? A_LFD : ld ? A_LD : laf ? A_LAF : A_NONE;
    case (act)
      A_DET: begin
        if (pv && d[1:0] != 2'b11) n.hdr = d;
        n.ip = 8'h00; n.pp = 8'h00; n.pd = 1'b0; n.err = 1'b0;
      end
      A_LFD: begin
        n.dout = c.hdr;
        n.ip   = c.ip ^ c.hdr;
      end
      A_LD: begin
        if (ff) n.fbr = d;
        else    n.dout = d;
        if (pv && !fs) n.ip = c.ip ^ d;
        if (!pv) begin
          n.pp  = d;
          n.lpv = 1'b1;
          if (!ff) n.pd = 1'b1;
        end
      end
      A_LAF: begin
        n.dout = c.fbr;
        if (c.lpv && !c.pd) n.pd = 1'b1;
      end
      default: ;
    endcase
    if (act != A_DET && c.pd) n.err = (c.ip != c.pp);
    if (ri) n.lpv = 1'b0;
    return n;
  endfunction

  // One clock: drive, predict, push expectation, then pop and compare 1 time unit after the edge.
  task automatic cycle(input logic da, lfd, ld, laf, fs, pv, ff, ri, input logic [7:0] d);
    exp_t e;
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf;
    full_state = fs; pkt_valid = pv; fifo_full = ff; rst_int_reg = ri; data_in = d;
    m = model_step(m, da, lfd, ld, laf, fs, pv, ff, ri, d);
    e.dout = m.dout; e.err = m.err; e.pd = m.pd; e.lpv = m.lpv;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    step++;
    if (sb_q.size() == 0) begin
      check($sformatf("sb_empty@%0d", step), 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("dout@%0d", step), 32'(dout), 32'(e.dout));
      check($sformatf("err@%0d", step), 32'(err), 32'(e.err));
      check($sformatf("parity_done@%0d", step), 32'(parity_done), 32'(e.pd));
      check($sformatf("low_pkt_valid@%0d", step), 32'(low_pkt_valid), 32'(e.lpv));
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dout"}, 32'(dout), 32'h0);
    check({tag, "_err"}, 32'(err), 32'h0);
    check({tag, "_pd"}, 32'(parity_done), 32'h0);
    check({tag, "_lpv"}, 32'(low_pkt_valid), 32'h0);
  endtask

  // Header, lfd, payload 0x01..0x08, then the parity byte (full_state optionally set on it).
  task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input logic fs_on_par);
    cycle(1, 0, 0, 0, 0, 1, 0, 0, hdr);
    cycle(0, 1, 0, 0, 0, 1, 0, 0, 8'h01);
    check("lfd_header", 32'(dout), 32'(hdr));
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 1, 0, 0, 1, 0, 0, 8'(i));
      check($sformatf("payload_%0d", i), 32'(dout), i);
    end
    cycle(0, 0, 1, 0, fs_on_par, 0, 0, 0, par);
  endtask

  initial begin
    resetn = 1'b1;
    {pkt_valid, fifo_full, detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg} = '0;
    data_in = 8'h00;
    m = model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clock);
    #1;
    resetn = 1'b0;

    // Good packet
    send_packet(8'h22, 8'h2A, 1'b0);
    check("good_pd", 32'(parity_done), 32'h1);
    check("good_lpv", 32'(low_pkt_valid), 32'h1);
    idle();
    check("good_err", 32'(err), 32'h0);

    // rst_int_reg clears low_pkt_valid
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    check("rst_int_lpv", 32'(low_pkt_valid), 32'h0);

    // Bad parity, then detect_add clears err/parity_done
    send_packet(8'h22, 8'h00, 1'b1);
    idle();
    check("bad_err", 32'(err), 32'h1);
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 8'h11);
    check("clr_err", 32'(err), 32'h0);
    check("clr_pd", 32'(parity_done), 32'h0);

    // Invalid address keeps prior header
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 8'h23);
    cycle(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    check("inv_addr_hdr", 32'(dout), 32'h11);

    // FIFO full on a payload byte, then on the parity byte
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 8'h00);
    cycle(1, 0, 0, 0, 0, 1, 0, 0, 8'h22);
    cycle(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cycle(0, 0, 1, 0, 0, 1, 0, 0, 8'h01);
    cycle(0, 0, 1, 0, 0, 1, 1, 0, 8'h5A);
    check("full_hold", 32'(dout), 32'h01);
    cycle(0, 0, 0, 0, 1, 1, 1, 0, 8'h5A);
    cycle(0, 0, 0, 1, 0, 1, 0, 0, 8'h5A);
    check("laf_dout", 32'(dout), 32'h5A);
    check("laf_pd_low", 32'(parity_done), 32'h0);
    cycle(0, 0, 1, 0, 0, 1, 0, 0, 8'h02);
    cycle(0, 0, 1, 0, 0, 0, 1, 0, 8'h7B);
    check("full_par_lpv", 32'(low_pkt_valid), 32'h1);
    check("full_par_pd", 32'(parity_done), 32'h0);
    cycle(0, 0, 0, 0, 1, 0, 1, 0, 8'h00);
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 8'h00);
    check("laf_par_dout", 32'(dout), 32'h7B);
    check("laf_par_pd", 32'(parity_done), 32'h1);
    idle();
    check("laf_par_err", 32'(err), 32'h0);

    // Strobe priority
    cycle(1, 1, 0, 0, 0, 1, 0, 0, 8'h31);
    check("prio_det_dout", 32'(dout), 32'h7B);
    cycle(0, 1, 1, 0, 0, 1, 0, 0, 8'h44);
    check("prio_lfd_dout", 32'(dout), 32'h31);

    // Asynchronous reset mid-packet
    cycle(0, 0, 1, 0, 0, 1, 0, 0, 8'h10);
    #2;
    resetn = 1'b1;
    #1;
    check_all_zero("async_rst");
    m = model_reset();
    #1;
    resetn = 1'b0;
    cycle(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    check("post_rst_hdr", 32'(dout), 32'h00);

    check("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
